// File: rtl/arb_rr4_decode_pkg.sv
// rtl/arb_rr4_decode_pkg.sv - shared state encoding and sizing for the round-robin arbiter
package arb_rr4_decode_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } arb_state_t;

    localparam int REQ_N            = 4;
    localparam int MAX_HOLD_DEFAULT = 8;

endpackage

// File: rtl/arb_rr4_decode_dec.sv
// rtl/arb_rr4_decode_dec.sv - 2-to-4 one-hot decoder with enable
//
// en  : when low the output is all zero
// id  : index to decode
// dec : one-hot result
module dec2to4 (
    input  logic       en,
    input  logic [1:0] id,
    output logic [3:0] dec
);

    assign dec = en ? (4'b0001 << id) : 4'b0000;

endmodule

// File: rtl/arb_rr4_decode_pick.sv
// rtl/arb_rr4_decode_pick.sv - combinational round-robin winner search over four requesters
//
// req     : request vector, bit i = requester i
// last_id : most recent owner; search starts at last_id+1 and ends at last_id
// win_id  : first requester found in that order (0 when no request)
// any_req : at least one request bit set
module rr_pick4
    import arb_rr4_decode_pkg::*;
(
    input  logic [REQ_N-1:0] req,
    input  logic [1:0]       last_id,
    output logic [1:0]       win_id,
    output logic             any_req
);

    logic       found;
    logic [1:0] idx;

    always_comb begin
        win_id = 2'b00;
        found  = 1'b0;
        idx    = 2'b00;
        for (int k = 1; k <= REQ_N; k++) begin
            // 2-bit addition wraps naturally, giving the modulo-4 search order
            idx = last_id + k[1:0];
            if (!found && req[idx]) begin
                win_id = idx;
                found  = 1'b1;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/arb_rr4_decode.sv
// rtl/arb_rr4_decode.sv - four-way round-robin arbiter with hold limit and registered one-hot grant
//
// clk       : rising-edge clock
// reset_n   : asynchronous active-low reset
// req       : level-sensitive request vector
// gnt       : one-hot grant, zero when idle
// gnt_id    : index of current owner (meaningful only with gnt_valid)
// gnt_valid : a grant is active
// hold_cnt  : cycles the current owner has held the grant, from 0
module arb_rr4_decode
    import arb_rr4_decode_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEFAULT,
    parameter int HOLD_W   = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [REQ_N-1:0]  req,
    output logic [REQ_N-1:0]  gnt,
    output logic [1:0]        gnt_id,
    output logic              gnt_valid,
    output logic [HOLD_W-1:0] hold_cnt
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    arb_state_t        state, state_d;
    logic [1:0]        last_id, last_d;
    logic [1:0]        id_d;
    logic [HOLD_W-1:0] hold_d;

    logic [1:0]        pick_last;
    logic [1:0]        win_id;
    logic              any_req;
    logic [REQ_N-1:0]  own_mask;
    logic              others;

    // While owning, any change of owner treats the current owner as the
    // most recent one, so the search starts just past gnt_id.
    assign pick_last = (state == ST_OWN) ? gnt_id : last_id;
    assign own_mask  = REQ_N'(1) << gnt_id;
    assign others    = |(req & ~own_mask);

    rr_pick4 u_pick (
        .req     (req),
        .last_id (pick_last),
        .win_id  (win_id),
        .any_req (any_req)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            gnt_id   <= 2'b00;
            hold_cnt <= '0;
            last_id  <= 2'b11;
        end else begin
            state    <= state_d;
            gnt_id   <= id_d;
            hold_cnt <= hold_d;
            last_id  <= last_d;
        end
    end

    always_comb begin
        state_d = state;
        id_d    = gnt_id;
        hold_d  = hold_cnt;
        last_d  = last_id;
        case (state)
            ST_IDLE: begin
                hold_d = '0;
                if (any_req) begin
                    state_d = ST_OWN;
                    id_d    = win_id;
                end
            end
            ST_OWN: begin
                if (!req[gnt_id]) begin
                    // Release wins over hold expiry; hand over with no idle bubble.
                    last_d = gnt_id;
                    hold_d = '0;
                    if (others) begin
                        id_d = win_id;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (others && hold_cnt == HOLD_LAST) begin
                    last_d = gnt_id;
                    id_d   = win_id;
                    hold_d = '0;
                end else if (!others) begin
                    // Sole requester: saturate rather than wrap.
                    if (hold_cnt != HOLD_LAST) begin
                        hold_d = hold_cnt + HOLD_W'(1);
                    end
                end else begin
                    hold_d = hold_cnt + HOLD_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                hold_d  = '0;
            end
        endcase
    end

    assign gnt_valid = (state == ST_OWN);

    dec2to4 u_dec (
        .en  (gnt_valid),
        .id  (gnt_id),
        .dec (gnt)
    );

endmodule

// File: doc/arb_rr4_decode.md
Name: arb_rr4_decode

Overview:
- 4-requester round-robin arbiter that owns one shared resource and issues a registered one-hot grant.
- The winner index is held in a 2-bit register; the team's 2-to-4 decoder drives gnt from that index.
- Sits between up to four masters and the shared datapath.
- Enforces fairness by forcing rotation after MAX_HOLD cycles when other requesters are waiting.

Parameters:
- MAX_HOLD, 8, maximum consecutive cycles one owner may hold the grant while another request is pending; legal range 2..15.
- HOLD_W, 4, width of the hold counter; must satisfy 2^HOLD_W > MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- req  input  4  request vector; bit i = requester i; level-sensitive
- gnt  output  4  one-hot grant, all zero when idle; registered
- gnt_id  output  2  index of current owner; valid only when gnt_valid=1
- gnt_valid  output  1  high when gnt is nonzero
- hold_cnt  output  HOLD_W  cycles the current owner has held the grant, starting at 0

Behaviour:
- Reset (reset_n=0, asynchronous):
  - gnt=4'b0000, gnt_id=2'b00, gnt_valid=0, hold_cnt=0, state=IDLE.
  - Internal last_id=2'b11, so requester 0 has first priority after reset.
- Reset asserted mid-grant drops the grant immediately, with no clock edge needed.
- Release is synchronous to clk.
- States are IDLE and OWN.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise pick the winner, go to OWN, and register gnt_id=winner, gnt_valid=1, hold_cnt=0.
  - Latency: req sampled at edge N gives gnt valid after edge N (one cycle).
- Winner selection: search order is last_id+1, last_id+2, last_id+3, last_id (mod 4). The first set req bit wins.
- OWN, evaluated each edge in priority order:
  - Release: if req[gnt_id]==0, set last_id=gnt_id.
    - If any other req is set, grant the next winner at the same edge; there is no idle bubble and hold_cnt=0.
    - Otherwise go to IDLE with gnt=0.
  - Forced rotation: if req[gnt_id]==1 and hold_cnt==MAX_HOLD-1 and another req bit is set, set last_id=gnt_id, grant the next winner, and set hold_cnt=0.
  - Sole requester: if req[gnt_id]==1 and no other req is set, keep the grant. hold_cnt increments and saturates at MAX_HOLD-1; it never wraps.
  - Otherwise keep the grant and increment hold_cnt.
- Simultaneous events:
  - An owner drop coinciding with hold expiry counts as a release.
  - A new request arriving on the same edge as a release is eligible in that selection.
- Invariants:
  - gnt is always either zero or one-hot.
  - gnt == decode(gnt_id) whenever gnt_valid=1.
  - hold_cnt=0 whenever gnt_valid=0.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE=1'b0 and ST_OWN=1'b1;
  - REQ_N=4;
  - the default MAX_HOLD.
- One natural sub-module, rr_pick4 (combinational): inputs req[3:0] and last_id[1:0]; outputs win_id[1:0] and any_req.
- gnt is produced by instantiating the existing 2-to-4 decoder on registered gnt_id, gated by gnt_valid.

Test Plan:
- Reset then req=4'b0000 for 5 cycles: gnt=0000, gnt_valid=0, hold_cnt=0 throughout.
- After reset, req=4'b1010 at edge N: gnt=0010 and gnt_id=1 after edge N. Drop req[1] at edge N+3: gnt=1000, gnt_id=3 after N+3, with no bubble.
- req=4'b1111 held constant, MAX_HOLD=8: grants rotate 0,1,2,3,0 with each owner held exactly 8 cycles. hold_cnt counts 0..7 then returns to 0.
- req=4'b0100 alone for 20 cycles: gnt=0100 stays steady and hold_cnt saturates at 7. Then assert req[0] while hold_cnt=7: gnt=0001 on the next edge.
- Owner 2 drops req at the same edge hold_cnt reaches 7, with req=4'b1001: treated as release, and gnt=1000 (search order 3 before 0).
- Assert reset_n=0 between edges while gnt=0001: gnt=0000 immediately. After release, req=4'b0011 gives gnt=0001 (last_id reset to 3).
